// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
//
// Contents:
//   div_state_e            - FSM state encoding (FREE / BYZERO / ON / END)
//   DIV_RESULT_*           - ready_o codes
//   DIV_START / DIV_STOP   - start_i codes driven by EX
//   DIV_SIGNED / DIV_UNSIGNED - signed_div_i codes
//   EXE_DIV_OP / EXE_DIVU_OP  - aluop codes that route to this unit
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam logic DIV_SIGNED   = 1'b1;
    localparam logic DIV_UNSIGNED = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step (purely combinational).
//
// Ports:
//   rem_i      [WIDTH:0]   current partial remainder R
//   bit_i                  next dividend bit (MSB first)
//   divisor_i  [WIDTH-1:0] divisor magnitude
//   rem_o      [WIDTH:0]   new partial remainder
//   q_o                    quotient bit produced by this step
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    // Shifted remainder carries one extra bit so the comparison never
    // loses the top of R, even though R stays below the divisor in practice.
    logic [WIDTH+1:0] shifted;

    assign shifted = {rem_i, bit_i};

    always_comb begin
        // trial >= 0 is the same as shifted >= divisor
        q_o   = (shifted >= {2'b00, divisor_i});
        rem_o = q_o ? (shifted[WIDTH:0] - {1'b0, divisor_i}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV / DIVU in the execute stage.
// EX holds start_i until ready_o, then writes result_o into {HI, LO}.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   signed_div_i           1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
//   opdata1_i [WIDTH-1:0]  dividend; sampled at accept
//   opdata2_i [WIDTH-1:0]  divisor; sampled at accept
//   start_i                request, held until ready_o is seen
//   annul_i                flush: cancels a pending or running division
//   result_o [2*WIDTH-1:0] {remainder, quotient}
//   ready_o                result valid
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    // Dividend register doubles as the quotient register: each step shifts
    // the next dividend bit out of the top and the quotient bit into the bottom.
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               mode_q, mode_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;

    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quot_raw, rem_raw;
    logic [WIDTH-1:0]   quot_fin, rem_fin;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Result of the final step with sign fixup: quotient negative when the
    // operand signs differ, remainder takes the dividend's sign. MIN / -1
    // wraps naturally to MIN.
    always_comb begin
        quot_raw = {dvd_q[WIDTH-2:0], step_q};
        rem_raw  = step_rem[WIDTH-1:0];
        quot_fin = cond_negate(quot_raw, mode_q && (s1_q ^ s2_q));
        rem_fin  = cond_negate(rem_raw, mode_q && s1_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        result_d = result_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        s1_d     = s1_q;
        s2_d     = s2_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                        dvd_d   = magnitude(opdata1_i, signed_div_i);
                        dvs_d   = magnitude(opdata2_i, signed_div_i);
                        rem_d   = '0;
                        mode_d  = signed_div_i;
                        s1_d    = opdata1_i[WIDTH-1];
                        s2_d    = opdata2_i[WIDTH-1];
                        cnt_d   = '0;
                    end
                end
            end

            DIV_BYZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quot_raw;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_d = {rem_fin, quot_fin};
                        ready_d  = DIV_RESULT_READY;
                        state_d  = DIV_END;
                    end
                end
            end

            DIV_END: begin
                // EX keeps start_i high while it stalls; release when it lets go.
                if (start_i != DIV_START || annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded at accept.
    always_ff @(posedge clk) begin
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        rem_q  <= rem_d;
        mode_q <= mode_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a 32-bit and an 8-bit instance share the
// clock and reset. Expected {remainder, quotient} values are queued when a
// division is started and popped when ready_o rises.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        sgn32, start32, annul32, rdy32;
    logic [31:0] a32, b32;
    logic [63:0] res32;

    logic        sgn8, start8, annul8, rdy8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    div_iter #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn32),
        .opdata1_i    (a32),
        .opdata2_i    (b32),
        .start_i      (start32),
        .annul_i      (annul32),
        .result_o     (res32),
        .ready_o      (rdy32)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn8),
        .opdata1_i    (a8),
        .opdata2_i    (b8),
        .start_i      (start8),
        .annul_i      (annul8),
        .result_o     (res8),
        .ready_o      (rdy8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] sb32[$];
    logic [15:0] sb8[$];

    function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sd;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            q  = 32'(sa / sd);
            r  = 32'(sa % sd);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int sa, sd;
        logic [7:0] q, r;
        if (b == 8'd0) return 16'd0;
        if (s) begin
            sa = int'($signed(a));
            sd = int'($signed(b));
            q  = 8'(sa / sd);
            r  = 8'(sa % sd);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Stimulus helpers (no checking). The latency count includes the accepting edge.
    task automatic start_op32(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
    endtask

    task automatic start_op8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
    endtask

    task automatic wait_ready32(input bit drop, input bit scramble, output int lat, output bit seen);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (rdy32) seen = 1'b1;
            else begin
                if (drop) start32 = 1'b0;
                if (scramble) begin a32 = $urandom; b32 = $urandom; sgn32 = ~sgn32; end
            end
        end
    endtask

    task automatic wait_ready8(output int lat, output bit seen);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (rdy8) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sgn32 = 0; start32 = 0; annul32 = 0; a32 = '0; b32 = '0;
        sgn8 = 0; start8 = 0; annul8 = 0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rdy32 !== 1'b0) $display("FAIL reset_rdy32: got %b want 0", rdy32); else n_pass++;
        n_checks++; if (res32 !== 64'd0) $display("FAIL reset_res32: got %h want 0", res32); else n_pass++;
        n_checks++; if (rdy8 !== 1'b0) $display("FAIL reset_rdy8: got %b want 0", rdy8); else n_pass++;
        n_checks++; if (res8 !== 16'd0) $display("FAIL reset_res8: got %h want 0", res8); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat; bit seen; logic [63:0] exp;
        start_op32(1'b0, 32'd100, 32'd7);
        sb32.push_back(64'h00000002_0000000E);
        wait_ready32(1'b0, 1'b1, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || lat != 33) $display("FAIL udiv_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (res32 !== exp) $display("FAIL udiv_result: got %h want %h", res32, exp); else n_pass++;
        @(negedge clk); start32 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rdy32 !== 1'b0 || res32 !== 64'd0)
            $display("FAIL udiv_release: got rdy=%b res=%h want 0/0", rdy32, res32); else n_pass++;
    endtask

    task automatic test_signed;
        int lat; bit seen; logic [63:0] exp;
        start_op32(1'b1, 32'hFFFFFFF9, 32'h2);
        sb32.push_back(64'hFFFFFFFF_FFFFFFFD);
        wait_ready32(1'b0, 1'b0, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || res32 !== exp) $display("FAIL sdiv_m7_2: got %h want %h", res32, exp); else n_pass++;
        @(negedge clk); start32 = 1'b0;
        @(posedge clk); #1;
        // 7 / -2 with start dropped right after accept: must still complete.
        start_op32(1'b1, 32'd7, 32'hFFFFFFFE);
        sb32.push_back(64'h00000001_FFFFFFFD);
        wait_ready32(1'b1, 1'b0, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || lat != 33) $display("FAIL sdiv_drop_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (res32 !== exp) $display("FAIL sdiv_7_m2: got %h want %h", res32, exp); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rdy32 !== 1'b0 || res32 !== 64'd0)
            $display("FAIL sdiv_release: got rdy=%b res=%h want 0/0", rdy32, res32); else n_pass++;
    endtask

    task automatic test_div_zero;
        int lat; bit seen; logic [63:0] exp;
        for (int s = 0; s < 2; s++) begin
            start_op32(1'(s), 32'd5, 32'd0);
            sb32.push_back(64'd0);
            wait_ready32(1'b0, 1'b0, lat, seen);
            exp = sb32.pop_front();
            n_checks++; if (!seen || lat != 2) $display("FAIL divzero_latency s=%0d: got %0d want 2", s, lat); else n_pass++;
            n_checks++; if (res32 !== exp) $display("FAIL divzero_result s=%0d: got %h want %h", s, res32, exp); else n_pass++;
            @(negedge clk); start32 = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (rdy32 !== 1'b0) $display("FAIL divzero_release s=%0d: got %b want 0", s, rdy32); else n_pass++;
        end
    endtask

    task automatic test_annul;
        int lat; bit seen; bit early; logic [63:0] exp;
        early = 1'b0;
        start_op32(1'b0, 32'h12345678, 32'h11);
        @(posedge clk); #1;
        repeat (9) begin
            @(posedge clk); #1;
            if (rdy32) early = 1'b1;
        end
        @(negedge clk); annul32 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (early || rdy32 !== 1'b0 || res32 !== 64'd0)
            $display("FAIL annul_abort: got rdy=%b res=%h early=%b want 0/0/0", rdy32, res32, early); else n_pass++;
        @(negedge clk);
        annul32 = 1'b0; sgn32 = 1'b0; a32 = 32'd20; b32 = 32'd4;
        sb32.push_back(64'h00000000_00000005);
        wait_ready32(1'b0, 1'b0, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || lat != 33) $display("FAIL annul_restart_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (res32 !== exp) $display("FAIL annul_restart_result: got %h want %h", res32, exp); else n_pass++;
        @(negedge clk); start32 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid;
        int lat; bit seen; logic [63:0] exp;
        start_op32(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rdy32 !== 1'b0 || res32 !== 64'd0)
            $display("FAIL rst_mid: got rdy=%b res=%h want 0/0", rdy32, res32); else n_pass++;
        @(negedge clk); rst = 1'b0; start32 = 1'b0;
        start_op32(1'b0, 32'd1000, 32'd3);
        sb32.push_back(model32(1'b0, 32'd1000, 32'd3));
        wait_ready32(1'b0, 1'b0, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || lat != 33) $display("FAIL rst_restart_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (res32 !== exp) $display("FAIL rst_restart_result: got %h want %h", res32, exp); else n_pass++;
        @(negedge clk); start32 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_hold;
        int lat; bit seen; logic [63:0] exp;
        start_op32(1'b1, 32'h80000000, 32'hFFFFFFFF);
        sb32.push_back(64'h00000000_80000000);
        wait_ready32(1'b0, 1'b0, lat, seen);
        exp = sb32.pop_front();
        n_checks++; if (!seen || res32 !== exp) $display("FAIL overflow_result: got %h want %h", res32, exp); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1;
            n_checks++; if (rdy32 !== 1'b1 || res32 !== exp)
                $display("FAIL end_hold cyc%0d: got rdy=%b res=%h want 1/%h", i, rdy32, res32, exp); else n_pass++;
        end
        @(negedge clk); start32 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rdy32 !== 1'b0 || res32 !== 64'd0)
            $display("FAIL overflow_release: got rdy=%b res=%h want 0/0", rdy32, res32); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat; bit seen; logic [63:0] exp;
        logic s; logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            s = 1'(i % 2);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = 32'd0;
            start_op32(s, a, b);
            sb32.push_back(model32(s, a, b));
            wait_ready32(1'b0, 1'b0, lat, seen);
            exp = sb32.pop_front();
            n_checks++; if (!seen || lat != ((b == 32'd0) ? 2 : 33))
                $display("FAIL b2b_latency op%0d: got %0d", i, lat); else n_pass++;
            n_checks++; if (res32 !== exp)
                $display("FAIL b2b_result op%0d s=%0d %h/%h: got %h want %h", i, s, a, b, res32, exp); else n_pass++;
            @(negedge clk); start32 = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width8;
        int lat; bit seen; logic [15:0] exp;
        logic s; logic [7:0] a, b;
        start_op8(1'b0, 8'd200, 8'd3);
        sb8.push_back({8'd2, 8'd66});
        wait_ready8(lat, seen);
        exp = sb8.pop_front();
        n_checks++; if (!seen || lat != 9) $display("FAIL w8_latency: got %0d want 9", lat); else n_pass++;
        n_checks++; if (res8 !== exp) $display("FAIL w8_200_3: got %h want %h", res8, exp); else n_pass++;
        @(negedge clk); start8 = 1'b0;
        start_op8(1'b1, 8'h80, 8'h03);
        sb8.push_back({8'hFE, 8'hD6});
        wait_ready8(lat, seen);
        exp = sb8.pop_front();
        n_checks++; if (!seen || res8 !== exp) $display("FAIL w8_m128_3: got %h want %h", res8, exp); else n_pass++;
        @(negedge clk); start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s = 1'(i % 2);
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 7) begin a = 8'h80; b = 8'hFF; end
            start_op8(s, a, b);
            sb8.push_back(model8(s, a, b));
            wait_ready8(lat, seen);
            exp = sb8.pop_front();
            n_checks++; if (!seen || res8 !== exp || lat != ((b == 8'd0) ? 2 : 9))
                $display("FAIL w8_rand op%0d s=%0d %h/%h: got %h lat %0d want %h", i, s, a, b, res8, lat, exp); else n_pass++;
            @(negedge clk); start8 = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_rst_mid();
        test_overflow_hold();
        test_back_to_back();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
